// File: rtl/universal_shift_register.sv
// Parametrised shift/rotate register with parallel load, synchronous clear and
// multi-step sequences that run under a busy/done handshake.
module universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [2:0]       op,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] in,
    input  logic             sin,
    output logic [WIDTH-1:0] out,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_LSR  = 3'b010;
    localparam logic [2:0] OP_LSL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    logic [WIDTH-1:0] data_reg, data_next;
    logic             sout_reg, sout_next;
    logic             done_reg, done_next;
    logic [2:0]       op_reg, op_next;
    logic [CNT_W-1:0] rem_reg, rem_next;

    logic [WIDTH-1:0] lsr_data, lsl_data, ror_data, rol_data, asr_data;

    // One-bit neighbour networks; the end bits pick up the fill value.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == WIDTH - 1) begin : g_top
                assign lsr_data[gi] = sin;
                assign ror_data[gi] = data_reg[0];
                assign asr_data[gi] = data_reg[WIDTH-1];
            end else begin : g_notop
                assign lsr_data[gi] = data_reg[gi+1];
                assign ror_data[gi] = data_reg[gi+1];
                assign asr_data[gi] = data_reg[gi+1];
            end
            if (gi == 0) begin : g_bot
                assign lsl_data[gi] = sin;
                assign rol_data[gi] = data_reg[WIDTH-1];
            end else begin : g_notbot
                assign lsl_data[gi] = data_reg[gi-1];
                assign rol_data[gi] = data_reg[gi-1];
            end
        end
    endgenerate

    logic       busy_int;
    logic       is_shift_op;
    logic [2:0] exec_op;
    logic       do_exec;

    assign busy_int    = (rem_reg != '0);
    assign is_shift_op = (op >= OP_LSR) && (op <= OP_ASR);

    always_comb begin
        data_next = data_reg;
        sout_next = sout_reg;
        op_next   = op_reg;
        rem_next  = rem_reg;
        done_next = 1'b0;
        exec_op   = op;
        do_exec   = 1'b1;

        if (busy_int) begin
            // Inputs other than sin are ignored until the sequence drains.
            exec_op  = op_reg;
            rem_next = rem_reg - CNT_W'(1);
            if (rem_reg == CNT_W'(1)) begin
                done_next = 1'b1;
            end
        end else if (start && is_shift_op) begin
            if (amount == '0) begin
                do_exec   = 1'b0;
                done_next = 1'b1;
            end else begin
                op_next  = op;
                rem_next = amount - CNT_W'(1);
                if (amount == CNT_W'(1)) begin
                    done_next = 1'b1;
                end
            end
        end

        if (do_exec) begin
            case (exec_op)
                OP_HOLD: data_next = data_reg;
                OP_LOAD: data_next = in;
                OP_LSR: begin
                    data_next = lsr_data;
                    sout_next = data_reg[0];
                end
                OP_LSL: begin
                    data_next = lsl_data;
                    sout_next = data_reg[WIDTH-1];
                end
                OP_ROR: begin
                    data_next = ror_data;
                    sout_next = data_reg[0];
                end
                OP_ROL: begin
                    data_next = rol_data;
                    sout_next = data_reg[WIDTH-1];
                end
                OP_ASR: begin
                    data_next = asr_data;
                    sout_next = data_reg[0];
                end
                OP_CLR:  data_next = '0;
                default: data_next = data_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            data_reg <= '0;
            sout_reg <= 1'b0;
            done_reg <= 1'b0;
            op_reg   <= OP_HOLD;
            rem_reg  <= '0;
        end else begin
            data_reg <= data_next;
            sout_reg <= sout_next;
            done_reg <= done_next;
            op_reg   <= op_next;
            rem_reg  <= rem_next;
        end
    end

    assign out  = data_reg;
    assign sout = sout_reg;
    assign busy = busy_int;
    assign done = done_reg;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register (WIDTH=8, CNT_W=4) with
// hand-computed expectations checked by immediate assertions.
module tb_universal_shift_register;

    logic       clk;
    logic       clr;
    logic [2:0] op;
    logic       start;
    logic [3:0] amount;
    logic [7:0] in;
    logic       sin;
    logic [7:0] out;
    logic       sout;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    universal_shift_register #(.WIDTH(8), .CNT_W(4)) dut (
        .clk    (clk),
        .clr    (clr),
        .op     (op),
        .start  (start),
        .amount (amount),
        .in     (in),
        .sin    (sin),
        .out    (out),
        .sout   (sout),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [7:0] e_out, input logic e_sout,
                               input logic e_busy, input logic e_done);
        check({tag, ".out"},  32'(out),  32'(e_out));
        check({tag, ".sout"}, 32'(sout), 32'(e_sout));
        check({tag, ".busy"}, 32'(busy), 32'(e_busy));
        check({tag, ".done"}, 32'(done), 32'(e_done));
        $display("t=%0t %s out=%02h sout=%0b busy=%0b done=%0b", $time, tag, out, sout, busy, done);
    endtask

    initial begin
        clr = 1'b0; op = 3'b000; start = 1'b0; amount = 4'd0; in = 8'h00; sin = 1'b0;
        #12;
        check_state("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        clr = 1'b1;

        // Load and hold
        op = 3'b001; in = 8'hA5; tick();
        check_state("load_a5", 8'hA5, 1'b0, 1'b0, 1'b0);
        op = 3'b000; tick(); tick(); tick();
        check_state("hold3", 8'hA5, 1'b0, 1'b0, 1'b0);

        // Single-step shifts
        op = 3'b010; sin = 1'b1; tick();
        check_state("lsr_sin1", 8'hD2, 1'b1, 1'b0, 1'b0);
        op = 3'b011; sin = 1'b0; tick();
        check_state("lsl_sin0", 8'hA4, 1'b1, 1'b0, 1'b0);

        // Multi-step rotate right by 3 from 81, op change while busy ignored
        op = 3'b001; in = 8'h81; tick();
        start = 1'b1; op = 3'b100; amount = 4'd3; tick();
        check_state("ror3_s1", 8'hC0, 1'b1, 1'b1, 1'b0);
        start = 1'b0; op = 3'b001; in = 8'hFF; tick();
        check_state("ror3_s2", 8'h60, 1'b0, 1'b1, 1'b0);
        tick();
        check_state("ror3_done", 8'h30, 1'b0, 1'b0, 1'b1);
        op = 3'b000; tick();
        check_state("ror3_after", 8'h30, 1'b0, 1'b0, 1'b0);

        // Arithmetic shift right by 10 (count exceeds width)
        op = 3'b001; in = 8'h90; tick();
        start = 1'b1; op = 3'b110; amount = 4'd10; tick();
        check_state("asr10_s1", 8'hC8, 1'b0, 1'b1, 1'b0);
        start = 1'b0; op = 3'b000;
        for (int i = 2; i <= 9; i++) begin
            tick();
            check($sformatf("asr10_busy_s%0d", i), 32'(busy), 32'd1);
            check($sformatf("asr10_nodone_s%0d", i), 32'(done), 32'd0);
        end
        tick();
        check_state("asr10_done", 8'hFF, 1'b1, 1'b0, 1'b1);
        tick();
        check_state("asr10_after", 8'hFF, 1'b1, 1'b0, 1'b0);

        // Zero-step request
        op = 3'b001; in = 8'h90; tick();
        start = 1'b1; op = 3'b110; amount = 4'd0; tick();
        check_state("asr0_done", 8'h90, 1'b1, 1'b0, 1'b1);
        start = 1'b0; op = 3'b000; tick();
        check_state("asr0_after", 8'h90, 1'b1, 1'b0, 1'b0);

        // Abort with reset mid-sequence
        op = 3'b001; in = 8'h01; tick();
        start = 1'b1; op = 3'b011; amount = 4'd5; sin = 1'b0; tick();
        check_state("abort_s1", 8'h02, 1'b0, 1'b1, 1'b0);
        start = 1'b0; op = 3'b000; tick();
        check_state("abort_s2", 8'h04, 1'b0, 1'b1, 1'b0);
        #2 clr = 1'b0;
        #1;
        check_state("abort_async", 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        check_state("abort_held", 8'h00, 1'b0, 1'b0, 1'b0);
        clr = 1'b1;

        // Re-run the sequence to completion
        op = 3'b001; in = 8'h01; tick();
        start = 1'b1; op = 3'b011; amount = 4'd5; tick();
        start = 1'b0; op = 3'b000;
        tick(); tick(); tick();
        check_state("rerun_s4", 8'h10, 1'b0, 1'b1, 1'b0);
        tick();
        check_state("rerun_done", 8'h20, 1'b0, 1'b0, 1'b1);

        // Back-to-back start in the done cycle
        start = 1'b1; op = 3'b101; amount = 4'd2; tick();
        check_state("b2b_s1", 8'h40, 1'b0, 1'b1, 1'b0);
        start = 1'b0; op = 3'b000; tick();
        check_state("b2b_done", 8'h80, 1'b0, 1'b0, 1'b1);
        tick();
        check_state("b2b_after", 8'h80, 1'b0, 1'b0, 1'b0);

        // Single-step sequence: one step and a done pulse, no busy
        start = 1'b1; op = 3'b100; amount = 4'd1; tick();
        check_state("n1_done", 8'h40, 1'b0, 1'b0, 1'b1);
        start = 1'b0; op = 3'b000; tick();
        check_state("n1_after", 8'h40, 1'b0, 1'b0, 1'b0);

        // Start with a non-shift op acts as a plain single op
        op = 3'b001; in = 8'h03; tick();
        op = 3'b010; sin = 1'b0; tick();
        check_state("lsr_sout1", 8'h01, 1'b1, 1'b0, 1'b0);
        start = 1'b1; op = 3'b111; amount = 4'd4; tick();
        check_state("clr_start", 8'h00, 1'b1, 1'b0, 1'b0);
        start = 1'b0; op = 3'b000; tick();
        check_state("clr_after", 8'h00, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
